imem_arbiter: RTL and testbench
===============================

IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4, giving the maximum consecutive contended fetch wins before host priority is forced (range 1..15).
REQ-002 SHALL have parameter ADDR_W, default 12, giving the word-address width.
REQ-003 SHALL have port clk_i, input, 1, the single clock.
REQ-004 SHALL have port rst_ni, input, 1, the asynchronous active-low reset.
REQ-005 SHALL have port f_req_i, input, 1, the fetch read request.
REQ-006 SHALL have port f_addr_i, input, ADDR_W, the fetch word address.
REQ-007 SHALL have port f_gnt_o, output, 1, the fetch grant.
REQ-008 SHALL have ports f_rvalid_o, output, 1, and f_rdata_o, output, 32, carrying the fetch response.
REQ-009 SHALL have ports h_req_i, input, 1, and h_we_i, input, 1, for the host/loader request and write enable.
REQ-010 SHALL have ports h_addr_i, input, ADDR_W; h_wdata_i, input, 32; and h_be_i, input, 4 (byte enables).
REQ-011 SHALL have port h_lock_i, input, 1, requesting exclusive host ownership for program load.
REQ-012 SHALL have ports h_gnt_o, output, 1; h_rvalid_o, output, 1; and h_rdata_o, output, 32.
REQ-013 SHALL have port locked_o, output, 1, which is high in state LOCKED.
REQ-014 SHALL have memory-side ports mem_req_o, output, 1; mem_we_o, output, 1; mem_addr_o, output, ADDR_W; mem_wdata_o, output, 32; and mem_wmask_o, output, 4.
REQ-015 SHALL have memory-side ports mem_rdata_i, input, 32, and mem_rvalid_i, input, 1.

Function
REQ-016 SHALL grant at most one requester per cycle; grants are combinational, in the same cycle as the request; mem_req_o = f_gnt_o | h_gnt_o.
REQ-017 Memory fields SHALL be muxed from the granted requester; for a fetch grant, mem_we_o=0 and mem_wmask_o=0.
REQ-018 For a host write, mem_wmask_o SHALL equal h_be_i; otherwise it SHALL be 4'b0000.
REQ-019 In state RUN, the host SHALL win when only the host requests, or when the starvation counter equals STARVE_MAX; otherwise fetch wins.
REQ-020 The starvation counter SHALL increment on each cycle where both requesters are active and fetch wins, clear when the host is granted, and hold otherwise; it SHALL saturate at STARVE_MAX.
REQ-021 An owner register SHALL capture {valid, id} on every grant.
REQ-022 Reads: mem_rvalid_i/mem_rdata_i SHALL route to the owner captured one cycle earlier; the response appears exactly 1 cycle after grant.
REQ-023 A host write SHALL produce h_rvalid_o=1 with h_rdata_o=0 one cycle after grant, as a write acknowledgement.
REQ-024 The non-owner rvalid SHALL be 0; the non-owner rdata SHALL be 0.
REQ-025 The FSM SHALL have three states: RUN, DRAIN and LOCKED.
REQ-026 RUN SHALL go to DRAIN when h_lock_i=1; in DRAIN no fetch grant is given, but host grants are allowed.
REQ-027 DRAIN SHALL go to LOCKED when no fetch response is outstanding, which takes at most 1 cycle.
REQ-028 LOCKED: f_gnt_o SHALL be 0; the host SHALL be granted whenever h_req_i=1; the state SHALL go to RUN when h_lock_i=0.
REQ-029 Dropping h_lock_i while in DRAIN SHALL return the FSM directly to RUN.
REQ-030 Requests are not latched: a requester that is not granted SHALL hold its request and fields until granted.
REQ-031 A response arriving in the same cycle as a new grant SHALL be routed by the previous owner; pipelined back-to-back grants SHALL be supported at 1 per cycle.

Reset
REQ-032 Asserting rst_ni low SHALL asynchronously clear the FSM to RUN, the counter to 0, and owner.valid to 0; all *_rvalid_o, locked_o and rdata outputs SHALL be 0.
REQ-033 A reset mid-operation SHALL drop any in-flight response: no rvalid is issued after reset deasserts.

Structure
REQ-034 Package imem_arb_pkg SHALL hold the state enum (RUN, DRAIN, LOCKED), the owner id enum (OWN_FETCH, OWN_HOST) and the STARVE_MAX default.
REQ-035 The block SHALL be a single module with no sub-module; the instruction memory is instantiated by the parent.

Verification
REQ-036 Fetch-only traffic, addresses 0x000..0x003 back-to-back -> f_gnt_o=1 for 4 cycles; f_rvalid_o each following cycle with the memory data; h_rvalid_o=0 throughout.
REQ-037 Both requesting continuously, STARVE_MAX=4 -> grant pattern F,F,F,F,H repeating; the counter returns to 0 after each H.
REQ-038 Host write at 0x7FF, data 0xDEADBEEF, be 4'b0011 -> mem_wmask_o=4'b0011 and mem_we_o=1 in the grant cycle; h_rvalid_o=1 and h_rdata_o=0 on the next cycle.
REQ-039 h_lock_i raised in the cycle after a fetch grant -> DRAIN for 1 cycle, the fetch response still delivered, then locked_o=1; a held f_req_i gets no grant until h_lock_i=0.
REQ-040 rst_ni asserted in the cycle after a host read grant -> no h_rvalid_o after release; all outputs 0; FSM in RUN.

Source files
------------

// File: rtl/imem_arb_pkg.sv
// Shared types for the instruction-memory arbiter: FSM states, owner ids
// and the default starvation limit.
package imem_arb_pkg;

  localparam int STARVE_MAX_DEFAULT = 4;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    LOCKED = 2'd2
  } state_e;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_HOST  = 1'b1
  } owner_id_e;

  // Who was granted last cycle, and whether that grant was a host write
  // (a write is acknowledged locally instead of waiting for memory data).
  typedef struct packed {
    logic      valid;
    owner_id_e id;
    logic      we;
  } owner_t;

endpackage

// File: rtl/imem_arbiter.sv
// Two-port arbiter in front of a single-ported instruction memory.
// The fetch unit and a host/loader share the memory; grants are combinational,
// responses come back one cycle later and are routed to the recorded owner.
// The host can lock the memory for program load; fetch is drained first.
module imem_arbiter
  import imem_arb_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT,
  parameter int ADDR_W     = 12
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  // fetch port
  input  logic              f_req_i,
  input  logic [ADDR_W-1:0] f_addr_i,
  output logic              f_gnt_o,
  output logic              f_rvalid_o,
  output logic [31:0]       f_rdata_o,
  // host / loader port
  input  logic              h_req_i,
  input  logic              h_we_i,
  input  logic [ADDR_W-1:0] h_addr_i,
  input  logic [31:0]       h_wdata_i,
  input  logic [3:0]        h_be_i,
  input  logic              h_lock_i,
  output logic              h_gnt_o,
  output logic              h_rvalid_o,
  output logic [31:0]       h_rdata_o,
  output logic              locked_o,
  // memory side
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic [3:0]        mem_wmask_o,
  input  logic [31:0]       mem_rdata_i,
  input  logic              mem_rvalid_i
);

  localparam int               CNT_W   = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  state_e           state_q;
  logic             locked_q;
  logic [CNT_W-1:0] starve_q;
  owner_t           owner_q;
  logic             f_win;
  logic             h_win;
  logic             starved;

  assign starved = (starve_q == CNT_MAX);

  // Pick at most one winner this cycle; fetch is shut out outside RUN.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would infer a latch.
    f_win = 1'b0;
    h_win = 1'b0;
    case (state_q)
      RUN: begin
        h_win = h_req_i && (!f_req_i || starved);
        f_win = f_req_i && !h_win;
      end
      default: h_win = h_req_i;
    endcase
  end

  assign f_gnt_o   = f_win;
  assign h_gnt_o   = h_win;
  assign mem_req_o = f_win | h_win;
  assign locked_o  = locked_q;

  // Drive the memory request fields from whichever side won.
  always_comb begin
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_wmask_o = 4'b0000;
    if (h_win) begin
      mem_we_o    = h_we_i;
      mem_addr_o  = h_addr_i;
      mem_wdata_o = h_we_i ? h_wdata_i : '0;
      mem_wmask_o = h_we_i ? h_be_i : 4'b0000;
    end else if (f_win) begin
      mem_addr_o  = f_addr_i;
    end
  end

  // Lock FSM; a fetch response is always at most one cycle old, so DRAIN
  // only ever needs a single cycle before the host owns the memory.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (!rst_ni) begin
      state_q  <= RUN;
      locked_q <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (h_lock_i) state_q <= DRAIN;
        end
        DRAIN: begin
          if (h_lock_i) begin
            state_q  <= LOCKED;
            locked_q <= 1'b1;
          end else begin
            state_q  <= RUN;
          end
        end
        LOCKED: begin
          if (!h_lock_i) begin
            state_q  <= RUN;
            locked_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= RUN;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

  // Starvation counter and owner record for routing next cycle's response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      starve_q <= '0;
      owner_q  <= '{valid: 1'b0, id: OWN_FETCH, we: 1'b0};
    end else begin
      if (h_win) begin
        starve_q <= '0;
      end else if (f_win && h_req_i && !starved) begin
        starve_q <= starve_q + 1'b1;
      end
      owner_q.valid <= f_win | h_win;
      owner_q.id    <= h_win ? OWN_HOST : OWN_FETCH;
      owner_q.we    <= h_win & h_we_i;
    end
  end

  // Route the memory response (or the local write ack) to last cycle's owner.
  always_comb begin
    f_rvalid_o = 1'b0;
    f_rdata_o  = '0;
    h_rvalid_o = 1'b0;
    h_rdata_o  = '0;
    if (owner_q.valid) begin
      if (owner_q.id == OWN_FETCH) begin
        f_rvalid_o = mem_rvalid_i;
        f_rdata_o  = mem_rvalid_i ? mem_rdata_i : '0;
      end else if (owner_q.we) begin
        h_rvalid_o = 1'b1;
      end else begin
        h_rvalid_o = mem_rvalid_i;
        h_rdata_o  = mem_rvalid_i ? mem_rdata_i : '0;
      end
    end
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: directed scenarios with literal
// expectations, then constrained-random traffic compared every cycle against
// a behavioural model of the arbitration rules and a reference memory.
module tb_imem_arbiter;

  localparam int ADDR_W      = 12;
  localparam int STARVE_MAX  = 4;
  localparam int MAX_PRINT   = 40;
  localparam int RAND_CYCLES = 3000;

  localparam int MODE_RUN    = 0;
  localparam int MODE_DRAIN  = 1;
  localparam int MODE_LOCKED = 2;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              f_req_i;
  logic [ADDR_W-1:0] f_addr_i;
  logic              f_gnt_o, f_rvalid_o;
  logic [31:0]       f_rdata_o;
  logic              h_req_i, h_we_i, h_lock_i;
  logic [ADDR_W-1:0] h_addr_i;
  logic [31:0]       h_wdata_i;
  logic [3:0]        h_be_i;
  logic              h_gnt_o, h_rvalid_o, locked_o;
  logic [31:0]       h_rdata_o;
  logic              mem_req_o, mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [31:0]       mem_wdata_o;
  logic [3:0]        mem_wmask_o;
  logic [31:0]       mem_rdata_i  = 32'h0;
  logic              mem_rvalid_i = 1'b0;

  imem_arbiter #(.STARVE_MAX(STARVE_MAX), .ADDR_W(ADDR_W)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .f_req_i     (f_req_i),
    .f_addr_i    (f_addr_i),
    .f_gnt_o     (f_gnt_o),
    .f_rvalid_o  (f_rvalid_o),
    .f_rdata_o   (f_rdata_o),
    .h_req_i     (h_req_i),
    .h_we_i      (h_we_i),
    .h_addr_i    (h_addr_i),
    .h_wdata_i   (h_wdata_i),
    .h_be_i      (h_be_i),
    .h_lock_i    (h_lock_i),
    .h_gnt_o     (h_gnt_o),
    .h_rvalid_o  (h_rvalid_o),
    .h_rdata_o   (h_rdata_o),
    .locked_o    (locked_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_wmask_o (mem_wmask_o),
    .mem_rdata_i (mem_rdata_i),
    .mem_rvalid_i(mem_rvalid_i)
  );

  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= MAX_PRINT)
        $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Power-up memory image, identical for the environment and the reference.
  function automatic logic [31:0] mem_init(input logic [ADDR_W-1:0] a);
    return 32'hC0DE0000 | 32'(a);
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // ---------------- memory environment (driven by the DUT) ----------------
  logic [31:0] env_wr [logic [ADDR_W-1:0]];

  always @(posedge clk_i) begin
    logic [31:0] cur;
    mem_rvalid_i <= 1'b0;
    mem_rdata_i  <= 32'hBAD00000 | 32'($urandom_range(0, 65535));
    if (mem_req_o) begin
      cur = env_wr.exists(mem_addr_o) ? env_wr[mem_addr_o] : mem_init(mem_addr_o);
      if (mem_we_o) begin
        env_wr[mem_addr_o] = merge_bytes(cur, mem_wdata_o, mem_wmask_o);
      end else begin
        mem_rvalid_i <= 1'b1;
        mem_rdata_i  <= cur;
      end
    end
  end

  // ---------------- behavioural model + per-cycle compare -----------------
  typedef struct {
    bit          host;
    logic [31:0] data;
  } resp_t;

  resp_t       exp_q[$];
  logic [31:0] ref_wr [logic [ADDR_W-1:0]];
  int          m_mode   = MODE_RUN;
  int          m_starve = 0;
  bit          m_fgnt   = 1'b0;
  bit          m_hgnt   = 1'b0;

  function automatic logic [31:0] ref_read(input logic [ADDR_W-1:0] a);
    if (ref_wr.exists(a)) return ref_wr[a];
    return mem_init(a);
  endfunction

  always @(negedge clk_i) begin
    resp_t r;
    bit    has_r, fw, hg, to_f, to_h, wr;
    if (!rst_ni) begin
      check("rst_f_rvalid", 32'(f_rvalid_o), 32'h0);
      check("rst_h_rvalid", 32'(h_rvalid_o), 32'h0);
      check("rst_f_rdata", f_rdata_o, 32'h0);
      check("rst_h_rdata", h_rdata_o, 32'h0);
      check("rst_locked", 32'(locked_o), 32'h0);
      exp_q.delete();
      m_mode   = MODE_RUN;
      m_starve = 0;
      m_fgnt   = 1'b0;
      m_hgnt   = 1'b0;
    end else begin
      has_r = exp_q.size() != 0;
      r     = has_r ? exp_q.pop_front() : '{host: 1'b0, data: 32'h0};
      to_f  = has_r && !r.host;
      to_h  = has_r && r.host;
      check("m_f_rvalid", 32'(f_rvalid_o), 32'(to_f));
      check("m_f_rdata", f_rdata_o, to_f ? r.data : 32'h0);
      check("m_h_rvalid", 32'(h_rvalid_o), 32'(to_h));
      check("m_h_rdata", h_rdata_o, to_h ? r.data : 32'h0);
      check("m_locked", 32'(locked_o), 32'(m_mode == MODE_LOCKED));

      if (m_mode == MODE_RUN) begin
        hg = h_req_i && (!f_req_i || m_starve == STARVE_MAX);
        fw = f_req_i && !hg;
      end else begin
        hg = h_req_i;
        fw = 1'b0;
      end
      wr = hg && h_we_i;
      check("m_f_gnt", 32'(f_gnt_o), 32'(fw));
      check("m_h_gnt", 32'(h_gnt_o), 32'(hg));
      check("m_mem_req", 32'(mem_req_o), 32'(fw || hg));
      check("m_mem_we", 32'(mem_we_o), 32'(wr));
      check("m_mem_wmask", 32'(mem_wmask_o), wr ? 32'(h_be_i) : 32'h0);
      if (fw) check("m_mem_addr_f", 32'(mem_addr_o), 32'(f_addr_i));
      if (hg) check("m_mem_addr_h", 32'(mem_addr_o), 32'(h_addr_i));
      if (wr) check("m_mem_wdata", mem_wdata_o, h_wdata_i);

      if (fw) exp_q.push_back('{host: 1'b0, data: ref_read(f_addr_i)});
      if (hg && !wr) exp_q.push_back('{host: 1'b1, data: ref_read(h_addr_i)});
      if (wr) begin
        exp_q.push_back('{host: 1'b1, data: 32'h0});
        ref_wr[h_addr_i] = merge_bytes(ref_read(h_addr_i), h_wdata_i, h_be_i);
      end

      if (hg) m_starve = 0;
      else if (fw && h_req_i) m_starve = m_starve + 1;

      case (m_mode)
        MODE_RUN:    if (h_lock_i) m_mode = MODE_DRAIN;
        MODE_DRAIN:  m_mode = h_lock_i ? MODE_LOCKED : MODE_RUN;
        default:     if (!h_lock_i) m_mode = MODE_RUN;
      endcase
      m_fgnt = fw;
      m_hgnt = hg;
    end
  end

  // ---------------- stimulus + literal expectations -----------------------
  task automatic settle();
    @(negedge clk_i);
    #1;
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    f_req_i   = 1'b0;
    f_addr_i  = '0;
    h_req_i   = 1'b0;
    h_we_i    = 1'b0;
    h_addr_i  = '0;
    h_wdata_i = 32'h0;
    h_be_i    = 4'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    h_lock_i = 1'b0;
    rst_ni   = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;

    // Reset state.
    settle();
    check("reset_locked", 32'(locked_o), 32'h0);
    check("reset_f_rvalid", 32'(f_rvalid_o), 32'h0);
    check("reset_h_rvalid", 32'(h_rvalid_o), 32'h0);
    check("reset_f_rdata", f_rdata_o, 32'h0);
    next_cycle();

    // Fetch-only burst, addresses 0..3 back-to-back.
    for (int i = 0; i < 4; i++) begin
      f_req_i  = 1'b1;
      f_addr_i = ADDR_W'(i);
      settle();
      check("burst_f_gnt", 32'(f_gnt_o), 32'h1);
      check("burst_h_rvalid", 32'(h_rvalid_o), 32'h0);
      if (i > 0) begin
        check("burst_f_rvalid", 32'(f_rvalid_o), 32'h1);
        check("burst_f_rdata", f_rdata_o, 32'hC0DE0000 + 32'(i - 1));
      end
      next_cycle();
    end
    f_req_i = 1'b0;
    settle();
    check("burst_last_rdata", f_rdata_o, 32'hC0DE0003);
    check("burst_last_h_rvalid", 32'(h_rvalid_o), 32'h0);
    next_cycle();

    // Both requesting continuously: F,F,F,F,H repeating.
    f_req_i  = 1'b1;
    f_addr_i = 12'h010;
    h_req_i  = 1'b1;
    h_addr_i = 12'h020;
    for (int i = 0; i < 10; i++) begin
      settle();
      check("starve_f_gnt", 32'(f_gnt_o), (i % 5 == 4) ? 32'h0 : 32'h1);
      check("starve_h_gnt", 32'(h_gnt_o), (i % 5 == 4) ? 32'h1 : 32'h0);
      next_cycle();
    end
    idle_inputs();
    settle();
    next_cycle();

    // Host partial write, then read back the merged word.
    h_req_i   = 1'b1;
    h_we_i    = 1'b1;
    h_addr_i  = 12'h7FF;
    h_wdata_i = 32'hDEADBEEF;
    h_be_i    = 4'b0011;
    settle();
    check("wr_h_gnt", 32'(h_gnt_o), 32'h1);
    check("wr_mem_we", 32'(mem_we_o), 32'h1);
    check("wr_mem_wmask", 32'(mem_wmask_o), 32'h3);
    check("wr_mem_addr", 32'(mem_addr_o), 32'h7FF);
    check("wr_mem_wdata", mem_wdata_o, 32'hDEADBEEF);
    next_cycle();
    idle_inputs();
    settle();
    check("wr_ack_rvalid", 32'(h_rvalid_o), 32'h1);
    check("wr_ack_rdata", h_rdata_o, 32'h0);
    check("wr_ack_f_rvalid", 32'(f_rvalid_o), 32'h0);
    next_cycle();
    h_req_i  = 1'b1;
    h_addr_i = 12'h7FF;
    settle();
    check("rd_mem_we", 32'(mem_we_o), 32'h0);
    check("rd_mem_wmask", 32'(mem_wmask_o), 32'h0);
    next_cycle();
    idle_inputs();
    settle();
    check("rd_h_rvalid", 32'(h_rvalid_o), 32'h1);
    check("rd_h_rdata", h_rdata_o, 32'hC0DEBEEF);
    next_cycle();

    // Lock raised the cycle after a fetch grant.
    f_req_i  = 1'b1;
    f_addr_i = 12'h005;
    settle();
    check("lk_f_gnt0", 32'(f_gnt_o), 32'h1);
    next_cycle();
    f_req_i  = 1'b0;
    h_lock_i = 1'b1;
    settle();
    check("lk_f_rvalid", 32'(f_rvalid_o), 32'h1);
    check("lk_f_rdata", f_rdata_o, 32'hC0DE0005);
    check("lk_locked_run", 32'(locked_o), 32'h0);
    next_cycle();
    f_req_i  = 1'b1;
    f_addr_i = 12'h006;
    settle();
    check("lk_drain_f_gnt", 32'(f_gnt_o), 32'h0);
    check("lk_drain_locked", 32'(locked_o), 32'h0);
    next_cycle();
    h_req_i  = 1'b1;
    h_addr_i = 12'h7FF;
    settle();
    check("lk_locked", 32'(locked_o), 32'h1);
    check("lk_locked_f_gnt", 32'(f_gnt_o), 32'h0);
    check("lk_locked_h_gnt", 32'(h_gnt_o), 32'h1);
    next_cycle();
    h_req_i = 1'b0;
    settle();
    check("lk_h_rdata", h_rdata_o, 32'hC0DEBEEF);
    check("lk_held_f_gnt", 32'(f_gnt_o), 32'h0);
    next_cycle();
    h_lock_i = 1'b0;
    settle();
    check("lk_release_f_gnt", 32'(f_gnt_o), 32'h0);
    check("lk_release_locked", 32'(locked_o), 32'h1);
    next_cycle();
    settle();
    check("lk_run_f_gnt", 32'(f_gnt_o), 32'h1);
    check("lk_run_locked", 32'(locked_o), 32'h0);
    next_cycle();
    f_req_i = 1'b0;
    settle();
    check("lk_run_f_rdata", f_rdata_o, 32'hC0DE0006);
    next_cycle();

    // Reset the cycle after a host read grant, taken while locked.
    h_lock_i = 1'b1;
    settle();
    next_cycle();
    settle();
    next_cycle();
    h_req_i  = 1'b1;
    h_addr_i = 12'h009;
    settle();
    check("rs_h_gnt", 32'(h_gnt_o), 32'h1);
    check("rs_locked_before", 32'(locked_o), 32'h1);
    next_cycle();
    idle_inputs();
    h_lock_i = 1'b0;
    rst_ni   = 1'b0;
    settle();
    check("rs_h_rvalid", 32'(h_rvalid_o), 32'h0);
    check("rs_locked", 32'(locked_o), 32'h0);
    next_cycle();
    rst_ni = 1'b1;
    settle();
    check("rs_after_h_rvalid", 32'(h_rvalid_o), 32'h0);
    check("rs_after_f_rvalid", 32'(f_rvalid_o), 32'h0);
    check("rs_after_h_rdata", h_rdata_o, 32'h0);
    check("rs_after_mem_req", 32'(mem_req_o), 32'h0);
    next_cycle();
    f_req_i  = 1'b1;
    f_addr_i = 12'h002;
    settle();
    check("rs_run_f_gnt", 32'(f_gnt_o), 32'h1);
    next_cycle();
    f_req_i = 1'b0;
    settle();
    check("rs_run_f_rdata", f_rdata_o, 32'hC0DE0002);
    next_cycle();

    // Randomized traffic; ungranted requests hold their fields.
    for (int c = 0; c < RAND_CYCLES; c++) begin
      if (!(f_req_i && !m_fgnt)) begin
        f_req_i  = ($urandom_range(0, 3) != 0);
        f_addr_i = ADDR_W'($urandom_range(0, 63));
      end
      if (!(h_req_i && !m_hgnt)) begin
        h_req_i   = ($urandom_range(0, 2) == 0);
        h_we_i    = 1'($urandom_range(0, 1));
        h_addr_i  = ADDR_W'($urandom_range(0, 63));
        h_wdata_i = $urandom;
        h_be_i    = 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 31) == 0) h_lock_i = !h_lock_i;
      next_cycle();
    end

    idle_inputs();
    h_lock_i = 1'b0;
    repeat (4) next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
